// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check controller.
//   state_e    : controller FSM states
//   FC_*       : fail codes reported on fail_code
//   ADDR_*     : Avalon word addresses of the system-ID slave
//   check_code : ID/timestamp comparison. The ID is checked first, so an ID
//                mismatch is reported even when the timestamp is also wrong.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] FC_OK  = 2'b00;
  localparam logic [1:0] FC_ID  = 2'b01;
  localparam logic [1:0] FC_TS  = 2'b10;
  localparam logic [1:0] FC_TMO = 2'b11;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  function automatic logic [1:0] check_code(input logic [31:0] id_word,
                                            input logic [31:0] ts_word,
                                            input logic [31:0] exp_id,
                                            input logic [31:0] exp_ts);
    if (id_word != exp_id)      return FC_ID;
    else if (ts_word != exp_ts) return FC_TS;
    else                        return FC_OK;
  endfunction

endpackage

// File: rtl/sysid_read_timer.sv
// Stall timer for one Avalon read. Shared by both read states of the
// controller.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : next count is zero (asserted whenever the read is not
//                  being held on a stall, which covers entry to a read state)
//   count_en     : increment for one stalled cycle
//   reached      : current count equals TIMEOUT
module sysid_read_timer #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic reached
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign reached = (cnt_q == TIMEOUT);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM master that reads the system-ID slave (ID word at address 0,
// timestamp word at address 1) and compares both to build-time values.
// Optional feature macro: SYSID_RETRY_EN -- when defined, a failed pass is
// retried from the ID read up to RETRY_MAX more times before done is raised.
//   clock, reset     : system clock, synchronous active-high reset
//   start            : one-cycle pulse, only honoured in IDLE
//   avm_address/read : read request, held stable while avm_waitrequest is high
//   avm_waitrequest  : slave stall; accept = avm_read && !avm_waitrequest
//   avm_readdata     : sampled on the accept cycle
//   busy             : high from the cycle after start through the done cycle
//   done             : one-cycle end-of-check pulse
//   pass, fail_code  : result, held until the next start
//   id_value         : last ID word read
//   ts_value         : last timestamp word read
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXP_ID    = 32'h0000_0000,
  parameter logic [31:0] EXP_TS    = 32'd1522111782,
  parameter logic [15:0] TIMEOUT   = 16'd255
`ifdef SYSID_RETRY_EN
  , parameter logic [1:0] RETRY_MAX = 2'd3
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        pass_q, pass_d;
  logic [1:0]  fc_q, fc_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic        tmr_clear, tmr_en, tmr_reached;
  logic        fail_evt;
  logic        can_retry;
  logic [1:0]  code;

  sysid_read_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmr_clear),
    .count_en (tmr_en),
    .reached  (tmr_reached)
  );

  // The timer only runs while a read is being held on a stall; any other
  // cycle (including the one that leaves a read state) zeroes it, so each
  // read state is entered with a fresh count.
  assign tmr_clear = !tmr_en;

  assign code = check_code(id_q, ts_q, EXP_ID, EXP_TS);

`ifdef SYSID_RETRY_EN
  logic [1:0] retry_q, retry_d;

  assign can_retry = (retry_q < RETRY_MAX);

  always_comb begin
    retry_d = retry_q;
    if (state_q == IDLE && start)  retry_d = '0;
    else if (fail_evt && can_retry) retry_d = retry_q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`else
  assign can_retry = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    fc_d        = fc_q;
    id_d        = id_q;
    ts_d        = ts_q;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    tmr_en      = 1'b0;
    fail_evt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          pass_d  = 1'b0;
          fc_d    = FC_OK;
        end
      end

      RD_ID, RD_TS: begin
        avm_read    = 1'b1;
        avm_address = (state_q == RD_TS) ? ADDR_TS : ADDR_ID;
        // Accept is tested before the timeout so an accept on the cycle the
        // count reaches TIMEOUT still succeeds.
        if (!avm_waitrequest) begin
          if (state_q == RD_ID) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
          end else begin
            ts_d    = avm_readdata;
            state_d = CHECK;
          end
        end else if (tmr_reached) begin
          fc_d     = FC_TMO;
          pass_d   = 1'b0;
          fail_evt = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      CHECK: begin
        fc_d   = code;
        pass_d = (code == FC_OK);
        if (code != FC_OK) fail_evt = 1'b1;
        else               state_d  = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any failure either restarts the read sequence or ends the check.
    if (fail_evt) state_d = can_retry ? RD_ID : DONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      fc_q    <= FC_OK;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign id_value  = id_q;
  assign ts_value  = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: a reactive Avalon slave configured per attempt
// (data words and stall lengths) plus a timeline reference model that derives
// the done cycle and the results from the read/timeout/retry rules.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1522111782;
  localparam int          TMO    = 255;
`ifdef SYSID_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  sysid_check_ctrl #(.EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .TIMEOUT(16'(TMO))) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .id_value(id_value), .ts_value(ts_value)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-attempt slave configuration (attempt = one pass of ID+TS reads).
  logic [31:0] c_id [4];
  logic [31:0] c_ts [4];
  int          c_wid[4];
  int          c_wts[4];

  // Reactive slave: decides waitrequest/readdata at each negedge from the
  // request visible in that cycle.
  int   att = -1;
  int   hold = 0;
  int   addr_viol = 0;
  bit   prev_read = 1'b0, prev_wait = 1'b0;
  logic prev_addr = 1'b0;

  always @(negedge clock) begin
    int idx, w;
    if (!busy) att = -1;
    if (avm_read) begin
      if (prev_read && prev_wait) begin
        if (avm_address !== prev_addr) addr_viol++;
        hold++;
      end else begin
        hold = 0;
        if (avm_address == 1'b0) att++;
      end
      idx = (att < 0) ? 0 : ((att > 3) ? 3 : att);
      w = avm_address ? c_wts[idx] : c_wid[idx];
      avm_waitrequest = (hold < w);
      avm_readdata    = avm_address ? c_ts[idx] : c_id[idx];
    end else begin
      hold = 0;
      avm_waitrequest = 1'($urandom);
      avm_readdata    = $urandom;
    end
    prev_read = avm_read;
    prev_wait = avm_waitrequest;
    prev_addr = avm_address;
  end

  // Reference model state carried between checks.
  logic [31:0] m_id = '0, m_ts = '0;

  // Walks the attempt timeline: start sampled at cycle 0, first read state
  // begins in cycle 1; a read waiting w cycles takes w+1 cycles, a stall past
  // TMO ends after TMO+1 cycles with a timeout; the compare takes 1 cycle.
  task automatic model(output int t, output logic [1:0] fc, output int n_att);
    int a = 0;
    t = 1;
    while (1) begin
      if (c_wid[a] > TMO) begin
        t += TMO + 1; fc = 2'd3;
      end else begin
        t += c_wid[a] + 1; m_id = c_id[a];
        if (c_wts[a] > TMO) begin
          t += TMO + 1; fc = 2'd3;
        end else begin
          t += c_wts[a] + 1; m_ts = c_ts[a]; t += 1;
          fc = (m_id != EXP_ID) ? 2'd1 : ((m_ts != EXP_TS) ? 2'd2 : 2'd0);
        end
      end
      if (fc != 2'd0 && RETRY && a < 3) a++;
      else break;
    end
    n_att = a + 1;
  endtask

  task automatic set_all(input logic [31:0] id, input logic [31:0] ts, input int wid, input int wts);
    for (int i = 0; i < 4; i++) begin
      c_id[i] = id; c_ts[i] = ts; c_wid[i] = wid; c_wts[i] = wts;
    end
  endtask

  task automatic run_check(input string tag, input bit extra_start, input bit start_at_done);
    int exp_t, cyc, n_att;
    logic [1:0] exp_fc;
    bit busy_bad = 1'b0;
    model(exp_t, exp_fc, n_att);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (!busy) busy_bad = 1'b1;
      start = (extra_start && cyc == 2);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".done_cycle"}, cyc, exp_t);
    chk({tag, ".busy_during"}, 32'(busy_bad), 0);
    chk({tag, ".busy_at_done"}, 32'(busy), 1);
    chk({tag, ".pass"}, 32'(pass), 32'(exp_fc == 2'd0));
    chk({tag, ".fail_code"}, 32'(fail_code), 32'(exp_fc));
    chk({tag, ".id_value"}, id_value, m_id);
    chk({tag, ".ts_value"}, ts_value, m_ts);
    if (RETRY) chk({tag, ".attempts"}, att + 1, n_att);
    if (start_at_done) start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".busy_after"}, 32'(busy), 0);
    @(negedge clock);
    chk({tag, ".still_idle"}, 32'(busy), 0);
    chk({tag, ".results_hold"}, {30'd0, fail_code}, 32'(exp_fc));
  endtask

  initial begin
    int dcnt;
    set_all(EXP_ID, EXP_TS, 0, 0);
    repeat (3) @(negedge clock);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.read", 32'(avm_read), 0);
    chk("rst.pass", 32'(pass), 0);
    chk("rst.fail_code", 32'(fail_code), 0);
    chk("rst.id", id_value, 0);
    chk("rst.ts", ts_value, 0);
    reset = 1'b0;
    @(negedge clock);

    set_all(EXP_ID, EXP_TS, 0, 0);          run_check("zero_wait", 1'b0, 1'b0);
    set_all(32'h1, EXP_TS, 0, 0);           run_check("id_bad", 1'b0, 1'b0);
    set_all(32'h1, 32'h5, 0, 1);            run_check("both_bad", 1'b0, 1'b0);
    set_all(EXP_ID, 32'h1234, 2, 0);        run_check("ts_bad", 1'b0, 1'b0);
    set_all(EXP_ID, EXP_TS, 0, 10);         run_check("ts_wait10", 1'b1, 1'b1);
    set_all(EXP_ID, EXP_TS, 100000, 0);     run_check("id_stuck", 1'b0, 1'b0);
    set_all(EXP_ID, EXP_TS, 1, 100000);     run_check("ts_stuck", 1'b0, 1'b0);
    set_all(EXP_ID, EXP_TS, TMO, 0);        run_check("accept_at_tmo", 1'b0, 1'b0);
    set_all(EXP_ID, EXP_TS, 0, TMO + 1);    run_check("tmo_edge", 1'b0, 1'b0);

    // Reset while the timestamp read is stalled.
    set_all(EXP_ID, EXP_TS, 0, 20);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (2) @(negedge clock);
    chk("midrst.in_ts_read", {31'd0, avm_read & avm_address}, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst.read", 32'(avm_read), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.pass", 32'(pass), 0);
    chk("midrst.fail_code", 32'(fail_code), 0);
    chk("midrst.id", id_value, 0);
    chk("midrst.ts", ts_value, 0);
    reset = 1'b0;
    m_id = '0; m_ts = '0;
    dcnt = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    chk("midrst.no_done", dcnt, 0);
    set_all(EXP_ID, EXP_TS, 0, 0);          run_check("after_rst", 1'b0, 1'b0);

    // TS wrong on the first two attempts, correct on the third.
    set_all(EXP_ID, EXP_TS, 0, 0);
    c_ts[0] = 32'hBAD0; c_ts[1] = 32'hBAD1;
    run_check("ts_retry", 1'b1, 1'b0);

    // Randomized checks.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) begin
        c_id[i]  = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
        c_ts[i]  = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
        c_wid[i] = $urandom_range(0, 4);
        c_wts[i] = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 5) == 0) c_wts[0] = 300;
      run_check($sformatf("rand%0d", n), 1'($urandom), 1'($urandom));
    end

    chk("addr_stable", addr_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
